hs32_mem_arbiter: RTL

//   Two-master arbiter directly upstream of the BRAM controller. It merges CPU

---
 rtl/hs32_mem_arbiter_if.sv | 47 ++++
 rtl/hs32_mem_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/hs32_mem_arbiter_if.sv
// Bus bundle for the hs32 memory arbiter: CPU request port, Wishbone slave port
// and the downstream stb/ack port toward the BRAM controller.
interface hs32_mem_arbiter_if #(
  parameter int unsigned AW = 12
) ();
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_dwrite;
  logic          cpu_rw;
  logic          cpu_stb;
  logic [31:0]   cpu_dread;
  logic          cpu_ack;

  logic          wb_cyc;
  logic          wb_stb;
  logic          wb_we;
  logic [31:0]   wb_adr;
  logic [31:0]   wb_wdat;
  logic [31:0]   wb_rdat;
  logic          wb_ack;

  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_dwrite;
  logic          mem_rw;
  logic          mem_stb;
  logic [31:0]   mem_dread;
  logic          mem_ack;

  // Arbiter side
  modport slave (
    input  cpu_addr, cpu_dwrite, cpu_rw, cpu_stb,
    output cpu_dread, cpu_ack,
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_wdat,
    output wb_rdat, wb_ack,
    output mem_addr, mem_dwrite, mem_rw, mem_stb,
    input  mem_dread, mem_ack
  );

  // Environment side: requesters plus the downstream memory
  modport master (
    output cpu_addr, cpu_dwrite, cpu_rw, cpu_stb,
    input  cpu_dread, cpu_ack,
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_wdat,
    input  wb_rdat, wb_ack,
    input  mem_addr, mem_dwrite, mem_rw, mem_stb,
    output mem_dread, mem_ack
  );
endinterface

// File: rtl/hs32_mem_arbiter.sv
// Two-master (CPU pulse / Wishbone classic) round-robin arbiter in front of the
// BRAM controller; downstream address, data and rw are registered and held per transaction.
module hs32_mem_arbiter #(
  parameter int unsigned AW      = 12,
  parameter logic [31:0] WB_BASE = 32'h3000_0000,
  parameter logic [31:0] WB_MASK = 32'hFFFF_F000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  hs32_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic          last_wb_q, last_wb_d;
  logic          grant_wb_q, grant_wb_d;
  logic          cpu_pend_q, cpu_pend_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic [31:0]   pend_dwrite_q, pend_dwrite_d;
  logic          pend_rw_q, pend_rw_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_dwrite_q, mem_dwrite_d;
  logic          mem_rw_q, mem_rw_d;
  logic [31:0]   cpu_dread_q, cpu_dread_d;
  logic [31:0]   wb_dread_q, wb_dread_d;

  logic cpu_req, wb_req, wb_hit;
  logic grant_cpu, grant_wb;

  assign cpu_req = bus.cpu_stb | cpu_pend_q;
  assign wb_req  = bus.wb_cyc & bus.wb_stb;
  assign wb_hit  = ((bus.wb_adr & WB_MASK) == WB_BASE);

  always_comb begin
    state_d       = state_q;
    last_wb_d     = last_wb_q;
    grant_wb_d    = grant_wb_q;
    cpu_pend_d    = cpu_pend_q;
    pend_addr_d   = pend_addr_q;
    pend_dwrite_d = pend_dwrite_q;
    pend_rw_d     = pend_rw_q;
    mem_addr_d    = mem_addr_q;
    mem_dwrite_d  = mem_dwrite_q;
    mem_rw_d      = mem_rw_q;
    cpu_dread_d   = cpu_dread_q;
    wb_dread_d    = wb_dread_q;
    grant_cpu     = 1'b0;
    grant_wb      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cpu_req && wb_req) begin
          grant_cpu = last_wb_q;
          grant_wb  = ~last_wb_q;
        end else begin
          grant_cpu = cpu_req;
          grant_wb  = wb_req;
        end
        // Out-of-window Wishbone access: answer with zero, never touch the BRAM
        if (grant_wb && !wb_hit) begin
          grant_wb_d = 1'b1;
          wb_dread_d = 32'h0;
          state_d    = StResp;
        end else if (grant_cpu) begin
          grant_wb_d   = 1'b0;
          last_wb_d    = 1'b0;
          cpu_pend_d   = 1'b0;
          mem_addr_d   = cpu_pend_q ? pend_addr_q   : bus.cpu_addr;
          mem_dwrite_d = cpu_pend_q ? pend_dwrite_q : bus.cpu_dwrite;
          mem_rw_d     = cpu_pend_q ? pend_rw_q     : bus.cpu_rw;
          state_d      = StIssue;
        end else if (grant_wb) begin
          grant_wb_d   = 1'b1;
          last_wb_d    = 1'b1;
          mem_addr_d   = bus.wb_adr[AW-1:0];
          mem_dwrite_d = bus.wb_wdat;
          mem_rw_d     = bus.wb_we;
          state_d      = StIssue;
        end
      end
      StIssue, StWait: begin
        if (bus.mem_ack) begin
          if (grant_wb_q) wb_dread_d = bus.mem_dread;
          else            cpu_dread_d = bus.mem_dread;
          state_d = StResp;
        end else begin
          state_d = StWait;
        end
      end
      StResp: state_d = StIdle;
    endcase

    // A second pulse while one is already pending is dropped
    if (bus.cpu_stb && !grant_cpu && !cpu_pend_q) begin
      cpu_pend_d    = 1'b1;
      pend_addr_d   = bus.cpu_addr;
      pend_dwrite_d = bus.cpu_dwrite;
      pend_rw_d     = bus.cpu_rw;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= StIdle;
      last_wb_q     <= 1'b1;
      grant_wb_q    <= 1'b0;
      cpu_pend_q    <= 1'b0;
      pend_addr_q   <= '0;
      pend_dwrite_q <= 32'h0;
      pend_rw_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_dwrite_q  <= 32'h0;
      mem_rw_q      <= 1'b0;
      cpu_dread_q   <= 32'h0;
      wb_dread_q    <= 32'h0;
    end else begin
      state_q       <= state_d;
      last_wb_q     <= last_wb_d;
      grant_wb_q    <= grant_wb_d;
      cpu_pend_q    <= cpu_pend_d;
      pend_addr_q   <= pend_addr_d;
      pend_dwrite_q <= pend_dwrite_d;
      pend_rw_q     <= pend_rw_d;
      mem_addr_q    <= mem_addr_d;
      mem_dwrite_q  <= mem_dwrite_d;
      mem_rw_q      <= mem_rw_d;
      cpu_dread_q   <= cpu_dread_d;
      wb_dread_q    <= wb_dread_d;
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_dwrite = mem_dwrite_q;
  assign bus.mem_rw     = mem_rw_q;
  assign bus.mem_stb    = (state_q == StIssue);
  assign bus.cpu_dread  = cpu_dread_q;
  assign bus.wb_rdat    = wb_dread_q;
  assign bus.cpu_ack    = (state_q == StResp) && !grant_wb_q;
  assign bus.wb_ack     = (state_q == StResp) && grant_wb_q;

endmodule
